lock_status_display: RTL
========================

# lock_status_display

Downstream indicator stage for the 3-bit combination-lock FSM. Consumes the lock's `locked`, `alarm`, `entimer` and `selsw` outputs. Drives:
- a seven-segment digit showing either the current entry step or the remaining unlock time;
- one-hot step LEDs;
- an unlock LED;
- a sticky, blinking alarm LED with an optional buzzer.

All outputs are registered. The block has no influence on the lock itself.

## Interface
- `BLINK_DIV`, 4: clock cycles per alarm-LED half-period; legal range 2..256.
- `UNLOCK_CYCLES`, 10: length in cycles of the lock's unlock window; the countdown starts at `UNLOCK_CYCLES-1`. Legal range 1..10.
- `clk` in 1: single clock; all state updates on posedge.
- `clear` in 1: synchronous, active-high reset.
- `locked` in 1: lock status from the lock FSM; 1 = locked.
- `alarm` in 1: active-low alarm from the lock FSM; 0 = wrong code entered.
- `entimer` in 1: high for the whole unlock window.
- `selsw` in 2: index of the code digit currently expected (0..3).
- `seg` out 7: active-low segments; `seg[0]`=a … `seg[6]`=g.
- `step_led` out 4: one-hot step indicator, `step_led[selsw]`.
- `unlock_led` out 1: 1 while the open window is displayed.
- `alarm_led` out 1: blinking alarm indicator.
- `buzzer` out 1: alarm buzzer drive.

## Operation
**States:** IDLE, OPEN, ALARM. Transitions are evaluated in this priority order:
1. `clear`=1 → IDLE. This holds in every state, including mid-countdown and mid-blink.
2. `alarm`=0 → ALARM from any state. Alarm wins over simultaneous `entimer`=1.
3. ALARM is sticky. Only `clear` leaves it, even if `alarm` returns to 1.
4. IDLE with `entimer`=1 → OPEN, with `remain` ← `UNLOCK_CYCLES-1`.
5. OPEN with `entimer`=1 → stay in OPEN. `remain` ← `remain-1`, saturating at 0 (no wrap).
6. OPEN with `entimer`=0 → IDLE, with `remain` ← 0.

**`remain`:** 4-bit unsigned. It is always in the range 0..9.

**Outputs per state, registered from next-state values:**
- **IDLE:**
  - `seg` = digit `selsw` (0..3);
  - `step_led` = one-hot(`selsw`);
  - `unlock_led` = 0; `alarm_led` = 0.
- **OPEN:**
  - `seg` = digit `remain`;
  - `step_led` = 0;
  - `unlock_led` = 1.
- **ALARM:**
  - `seg` = glyph "E" (7'b0000110);
  - `step_led` = 4'b1111;
  - `unlock_led` = 0.
- **`locked`:** when `locked`=0 is seen outside OPEN, the block treats it as OPEN entry exactly like `entimer`=1. `entimer` and `locked` are ORed for the OPEN-entry condition.

**Blink counter:**
- Cleared to 0 on entry to ALARM, and `alarm_led` is set to 1 on entry.
- Counts 0..`BLINK_DIV-1`. At the wrap it returns to 0 and toggles `alarm_led`.
- Held at 0 outside ALARM.

**Digit glyphs** (active-low, g..a order):
- 0 = 1000000
- 1 = 1111001
- 2 = 0100100
- 3 = 0110000
- 4 = 0011001
- 5 = 0010010
- 6 = 0000010
- 7 = 1111000
- 8 = 0000000
- 9 = 0010000

## Timing
**Reset values** (in the cycle after `clear` is sampled high):
- state IDLE, `remain` 0, blink counter 0;
- `seg` 7'b1000000, `step_led` 4'b0001;
- `unlock_led` 0, `alarm_led` 0, `buzzer` 0.

**Latency:** every output reflects inputs sampled at edge N during cycle N+1. This is exactly one cycle of latency.

**Unlock window:** `entimer` is high for cycles N..N+9.
- `seg` shows 9, 8, …, 0 over cycles N+1..N+10.
- IDLE with the step-0 display follows from cycle N+11.

**Alarm sampled at edge N:**
- `alarm_led` = 1 during cycles N+1..N+`BLINK_DIV`.
- It toggles every `BLINK_DIV` cycles thereafter.

## Configuration
- `LOCK_DISP_BUZZER_EN` defined:
  - `buzzer` is a registered copy of `alarm_led` while in ALARM, and 0 otherwise;
  - it has the same reset value (0) and the same latency as `alarm_led`.
- `LOCK_DISP_BUZZER_EN` undefined:
  - `buzzer` is tied to constant 0;
  - no buzzer register is present.

## Structure
- **Package `lock_disp_pkg`:**
  - state enum (IDLE/OPEN/ALARM);
  - `SEG_DIGIT[0:9]` glyph constants;
  - `SEG_E`;
  - `SEG_BLANK` (7'b1111111, reserved for future use).
- **Sub-module `seg7_encoder`:** purely combinational, 4-bit value to 7-bit active-low glyph. Values 10..15 map to `SEG_BLANK`.
- **Top module contents:** the FSM, the `remain` counter, the blink counter and the output registers.

## Test plan
1. **Reset.** `clear`=1 for 2 cycles, all other inputs 0 → `seg`=1000000, `step_led`=0001, all LEDs 0, `buzzer`=0.
2. **Step display.** Step `selsw` 0→1→2→3 with `alarm`=1, one per cycle → `step_led` 0001, 0010, 0100, 1000 and `seg` showing 0..3, each one cycle late.
3. **Unlock countdown.** `entimer`=1 for 10 cycles, `locked`=0 → `unlock_led`=1 and `seg` counts 9 down to 0 over 10 cycles. IDLE follows once `entimer` drops.
4. **Alarm blink.** With `BLINK_DIV`=4, pulse `alarm`=0 for 1 cycle → `seg`=E and `alarm_led` pattern 1111 0000 1111. The pattern persists after `alarm` returns to 1. `buzzer` matches `alarm_led` only with `LOCK_DISP_BUZZER_EN`.
5. **Simultaneous events.** `alarm`=0 and `entimer`=1 in the same cycle → ALARM, not OPEN. `clear`=1 mid-countdown (at `remain`=5) → IDLE next cycle with `seg`=0.
6. **Countdown saturation.** Hold `entimer`=1 for 14 cycles → `seg` stays 0 from cycle 11 through 15 with no wrap.

Source files
------------

// File: rtl/lock_disp_pkg.sv
// -----------------------------------------------------------------------------
// lock_disp_pkg
// Shared types and constants for the combination-lock status display.
//   disp_state_e : display FSM state (IDLE / OPEN / ALARM)
//   SEG_DIGIT    : active-low seven-segment glyphs for 0..9, bit order g..a
//   SEG_E        : "E" glyph shown while the alarm is latched
//   SEG_BLANK    : all segments off, shown for values that have no digit
//   step_onehot  : 2-bit step index to one-hot step LED pattern
// -----------------------------------------------------------------------------
package lock_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OPEN  = 2'd1,
        ALARM = 2'd2
    } disp_state_e;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,   // 0
        7'b1111001,   // 1
        7'b0100100,   // 2
        7'b0110000,   // 3
        7'b0011001,   // 4
        7'b0010010,   // 5
        7'b0000010,   // 6
        7'b1111000,   // 7
        7'b0000000,   // 8
        7'b0010000    // 9
    };

    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] STEP_ALL  = 4'b1111;

    function automatic logic [3:0] step_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/lock_status_display_seg7.sv
// -----------------------------------------------------------------------------
// seg7_encoder
// Purely combinational 4-bit value to active-low seven-segment glyph.
// Values 10..15 have no digit and are shown blank.
//   value_i : value to display (0..15)
//   seg_o   : active-low segments, seg_o[0]=a .. seg_o[6]=g
// -----------------------------------------------------------------------------
module seg7_encoder
    import lock_disp_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        seg_o = SEG_BLANK;
        case (value_i)
            4'd0: seg_o = SEG_DIGIT[0];
            4'd1: seg_o = SEG_DIGIT[1];
            4'd2: seg_o = SEG_DIGIT[2];
            4'd3: seg_o = SEG_DIGIT[3];
            4'd4: seg_o = SEG_DIGIT[4];
            4'd5: seg_o = SEG_DIGIT[5];
            4'd6: seg_o = SEG_DIGIT[6];
            4'd7: seg_o = SEG_DIGIT[7];
            4'd8: seg_o = SEG_DIGIT[8];
            4'd9: seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/lock_status_display.sv
// -----------------------------------------------------------------------------
// lock_status_display
// Indicator stage for the 3-bit combination lock. Shows the current entry step
// or the remaining unlock time on a seven-segment digit, drives one-hot step
// LEDs, an unlock LED and a sticky blinking alarm LED. All outputs registered,
// one cycle after the inputs they reflect.
//
// Parameters:
//   BLINK_DIV     : cycles per alarm-LED half period (2..256)
//   UNLOCK_CYCLES : unlock window length, countdown starts at UNLOCK_CYCLES-1
// Ports:
//   clk        : clock, all state updates on posedge
//   clear      : synchronous active-high reset
//   locked     : 1 = lock closed (0 outside OPEN acts like entimer)
//   alarm      : active-low alarm from the lock
//   entimer    : high for the whole unlock window
//   selsw      : index of the code digit currently expected
//   seg        : active-low segments, seg[0]=a .. seg[6]=g
//   step_led   : one-hot step indicator
//   unlock_led : open window displayed
//   alarm_led  : blinking alarm indicator
//   buzzer     : alarm buzzer drive
// Configuration:
//   LOCK_DISP_BUZZER_EN : when defined, buzzer is a registered copy of
//                         alarm_led in ALARM; otherwise buzzer is tied to 0.
// -----------------------------------------------------------------------------
module lock_status_display
    import lock_disp_pkg::*;
#(
    parameter int BLINK_DIV     = 4,
    parameter int UNLOCK_CYCLES = 10
)
(
    input  logic       clk,
    input  logic       clear,
    input  logic       locked,
    input  logic       alarm,
    input  logic       entimer,
    input  logic [1:0] selsw,
    output logic [6:0] seg,
    output logic [3:0] step_led,
    output logic       unlock_led,
    output logic       alarm_led,
    output logic       buzzer
);

    localparam int                 BLINK_W     = $clog2(BLINK_DIV);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);
    localparam logic [3:0]         REMAIN_INIT = 4'(UNLOCK_CYCLES - 1);

    disp_state_e        state_q, state_d;
    logic [3:0]         remain_q, remain_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               alarm_led_q, alarm_led_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         step_q, step_d;
    logic               unlock_q, unlock_d;

    logic [3:0]         disp_value;
    logic [6:0]         digit_glyph;

    // Next state, countdown and blink counter. clear is handled in the
    // register process, so this block only sees non-reset cycles.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        blink_d     = '0;
        alarm_led_d = 1'b0;

        if (state_q == ALARM) begin
            // Sticky: only clear leaves ALARM, whatever alarm does now.
            if (blink_q == BLINK_LAST) begin
                blink_d     = '0;
                alarm_led_d = ~alarm_led_q;
            end else begin
                blink_d     = blink_q + 1'b1;
                alarm_led_d = alarm_led_q;
            end
        end else if (!alarm) begin
            // Alarm beats a simultaneous open request; LED lights on entry.
            state_d     = ALARM;
            remain_d    = '0;
            alarm_led_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (entimer || !locked) begin
                        state_d  = OPEN;
                        remain_d = REMAIN_INIT;
                    end else begin
                        remain_d = '0;
                    end
                end
                OPEN: begin
                    if (entimer) begin
                        // Saturate at zero if the window outlasts the count.
                        remain_d = (remain_q == 4'd0) ? 4'd0 : remain_q - 4'd1;
                    end else begin
                        state_d  = IDLE;
                        remain_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state values so they land one cycle
    // after the inputs that caused them.
    assign disp_value = (state_d == OPEN) ? remain_d : {2'b00, selsw};

    seg7_encoder u_seg7 (
        .value_i (disp_value),
        .seg_o   (digit_glyph)
    );

    always_comb begin
        seg_d    = digit_glyph;
        step_d   = step_onehot(selsw);
        unlock_d = 1'b0;
        case (state_d)
            OPEN: begin
                step_d   = 4'b0000;
                unlock_d = 1'b1;
            end
            ALARM: begin
                seg_d  = SEG_E;
                step_d = STEP_ALL;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    // NOTE: every register here, including the display registers, is reset so
    // the outputs show a defined idle picture the cycle after clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            remain_q    <= '0;
            blink_q     <= '0;
            alarm_led_q <= 1'b0;
            seg_q       <= SEG_DIGIT[0];
            step_q      <= 4'b0001;
            unlock_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            blink_q     <= blink_d;
            alarm_led_q <= alarm_led_d;
            seg_q       <= seg_d;
            step_q      <= step_d;
            unlock_q    <= unlock_d;
        end
    end

    assign seg        = seg_q;
    assign step_led   = step_q;
    assign unlock_led = unlock_q;
    assign alarm_led  = alarm_led_q;

`ifdef LOCK_DISP_BUZZER_EN
    logic buzzer_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            buzzer_q <= 1'b0;
        end else begin
            buzzer_q <= (state_d == ALARM) && alarm_led_d;
        end
    end

    assign buzzer = buzzer_q;
`else
    assign buzzer = 1'b0;
`endif

endmodule
